// File: rtl/ce_seq_pkg.sv
// Shared types for the sequential unloaders: FSM state encoding and bit-order constants.
package ce_seq_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam bit LSB_FIRST     = 1'b0;
   localparam bit MSB_FIRST_ORD = 1'b1;

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down counter with a zero flag; holds at zero rather than wrapping.
module bit_down_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (dec && (count_reg != '0)) begin
         count_reg <= count_reg - W'(1);
      end
   end

   assign count = count_reg;
   assign zero  = (count_reg == '0);

endmodule

// File: rtl/piso_unload_n.sv
// Parallel-in, serial-out unloader: captures an N-bit word on a load handshake and
// streams it one bit per accepted beat, flagging the final bit with sout_last.
module piso_unload_n
   import ce_seq_pkg::*;
#(
   parameter int N         = 8,
   parameter int MSB_FIRST = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic [N-1:0] d,
   output logic         sout_valid,
   input  logic         sout_ready,
   output logic         sout,
   output logic         sout_last,
   output logic         busy
);

   localparam int              CW       = $clog2(N);
   localparam logic [CW-1:0]   LAST_IDX = CW'(N-1);

   state_t          state_reg, state_next;
   logic [N-1:0]    shift_reg, shift_next, shifted;
   logic            out_bit;
   logic [CW-1:0]   count;
   logic            zero;
   logic            in_shift, beat, load;

   generate
      if (MSB_FIRST == int'(MSB_FIRST_ORD)) begin : g_msb
         assign out_bit = shift_reg[N-1];
         assign shifted = {shift_reg[N-2:0], 1'b0};
      end else begin : g_lsb
         assign out_bit = shift_reg[0];
         assign shifted = {1'b0, shift_reg[N-1:1]};
      end
   endgenerate

   assign in_shift = (state_reg == SHIFT);
   assign beat     = in_shift && sout_ready;

   // Reload is allowed on the final accepted beat so consecutive words leave no gap.
   assign load_ready = !rst && (!in_shift || (beat && zero));
   assign load       = load_valid && load_ready;

   bit_down_counter #(.W(CW)) u_bit_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (LAST_IDX),
      .dec      (beat && !zero),
      .count    (count),
      .zero     (zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         shift_reg <= '0;
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      if (load) begin
         state_next = SHIFT;
         shift_next = d;
      end else if (beat) begin
         shift_next = shifted;
         if (zero) begin
            state_next = IDLE;
         end
      end
   end

   assign sout_valid = in_shift;
   assign busy       = in_shift;
   assign sout       = in_shift && out_bit;
   assign sout_last  = in_shift && (count == '0);

endmodule

// File: tb/tb_piso_unload_n.sv
// Scoreboard bench: two unloaders (LSB-first and MSB-first) share stimulus; a word-level
// model queues the expected bit stream and a monitor compares every cycle.
module tb_piso_unload_n;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         load_valid;
   logic [N-1:0] d;
   logic         sout_ready;

   logic lr0, sv0, so0, sl0, bz0;
   logic lr1, sv1, so1, sl1, bz1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      bit lsb;
      bit msb;
      bit last;
   } beat_t;

   beat_t exp_q[$];

   always #5 clk = ~clk;

   piso_unload_n #(.N(N), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr0), .d(d),
      .sout_valid(sv0), .sout_ready(sout_ready), .sout(so0), .sout_last(sl0), .busy(bz0)
   );

   piso_unload_n #(.N(N), .MSB_FIRST(1)) u_msb (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr1), .d(d),
      .sout_valid(sv1), .sout_ready(sout_ready), .sout(so1), .sout_last(sl1), .busy(bz1)
   );

   task automatic check(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares current outputs against the head of the expected stream.
   always @(negedge clk) begin
      bit    ev, elr, eb0, eb1, el;
      ev  = (exp_q.size() > 0);
      elr = !rst && ((exp_q.size() == 0) || ((exp_q.size() == 1) && sout_ready));
      eb0 = ev ? exp_q[0].lsb  : 1'b0;
      eb1 = ev ? exp_q[0].msb  : 1'b0;
      el  = ev ? exp_q[0].last : 1'b0;
      check("lsb_load_ready", lr0, elr);
      check("lsb_sout_valid", sv0, ev);
      check("lsb_busy",       bz0, ev);
      check("lsb_sout",       so0, eb0);
      check("lsb_sout_last",  sl0, el);
      check("msb_load_ready", lr1, elr);
      check("msb_sout_valid", sv1, ev);
      check("msb_busy",       bz1, ev);
      check("msb_sout",       so1, eb1);
      check("msb_sout_last",  sl1, el);
      if (ev && sout_ready) begin
         void'(exp_q.pop_front());
      end
   end

   // Reference model: a word is accepted whenever the previous one has fully drained.
   always @(negedge clk) begin
      #1;
      if (rst) begin
         exp_q.delete();
      end else if (load_valid && (exp_q.size() == 0)) begin
         for (int i = 0; i < N; i++) begin
            exp_q.push_back('{lsb: d[i], msb: d[N-1-i], last: (i == N-1)});
         end
      end
   end

   task automatic drive(input logic lv, input logic [N-1:0] dv, input logic sr, input logic r);
      load_valid = lv;
      d          = dv;
      sout_ready = sr;
      rst        = r;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b1, 1'b0);
   endtask

   initial begin
      logic [3:0] pat;
      pat        = 4'b1001;
      rst        = 1'b1;
      load_valid = 1'b0;
      d          = '0;
      sout_ready = 1'b1;
      drive(1'b0, '0, 1'b1, 1'b1);
      drive(1'b0, '0, 1'b1, 1'b1);
      idle(2);

      drive(1'b1, 8'hA5, 1'b1, 1'b0);
      idle(10);
      drive(1'b1, 8'h0F, 1'b1, 1'b0);
      idle(10);

      drive(1'b1, 8'h3C, 1'b1, 1'b0);
      for (int i = 0; i < 24; i++) drive(1'b0, '0, pat[3 - (i % 4)], 1'b0);
      idle(4);

      drive(1'b1, 8'hFF, 1'b1, 1'b0);
      repeat (8) drive(1'b1, 8'h00, 1'b1, 1'b0);
      idle(10);

      drive(1'b1, 8'hAA, 1'b1, 1'b0);
      idle(2);
      drive(1'b1, 8'h55, 1'b1, 1'b0);
      idle(10);

      drive(1'b1, 8'hC3, 1'b1, 1'b0);
      idle(3);
      drive(1'b0, '0, 1'b1, 1'b1);
      drive(1'b1, 8'h81, 1'b1, 1'b0);
      idle(10);

      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 1) == 1), N'($urandom), ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 63) == 0));
      end
      idle(12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
